// File: rtl/chinpo_mem_arbiter_if.sv
// Request/ack and memory-side bus shared by the CHINPO memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface chinpo_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/chinpo_mem_arbiter.sv
// Two-requester arbiter for the single-port CHINPO memory: CPU has priority,
// the loader is forced in after STARVE_MAX consecutive CPU grants it waited through.
module chinpo_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                CLK,
  input logic                Reset,
  chinpo_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       owner_ld;
  logic       we_q;
  logic       grant_ld;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  assign grant_ld      = bus.ld_req && (!bus.cpu_req || (starve_cnt == STARVE_LIM));
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      lat_cnt       <= 4'd0;
      starve_cnt    <= 4'd0;
      owner_ld      <= 1'b0;
      we_q          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.cpu_rdata <= {DATA_W{1'b0}};
      bus.ld_rdata  <= {DATA_W{1'b0}};
      bus.cpu_ack   <= 1'b0;
      bus.ld_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.ld_req) starve_cnt <= 4'd0;
          if (bus.cpu_req || bus.ld_req) begin
            owner_ld      <= grant_ld;
            we_q          <= grant_ld ? bus.ld_we    : bus.cpu_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= grant_ld ? bus.ld_we    : bus.cpu_we;
            bus.mem_addr  <= grant_ld ? bus.ld_addr  : bus.cpu_addr;
            bus.mem_wdata <= grant_ld ? bus.ld_wdata : bus.cpu_wdata;
            if (grant_ld)        starve_cnt <= 4'd0;
            else if (bus.ld_req) starve_cnt <= sat_inc(starve_cnt);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          lat_cnt    <= LAT_LOAD;
          state      <= WAIT;
        end
        WAIT: begin
          // Capture edge: read data lands only in the owner's register.
          if (lat_cnt == 4'd0) begin
            if (!we_q) begin
              if (owner_ld) bus.ld_rdata  <= bus.mem_rdata;
              else          bus.cpu_rdata <= bus.mem_rdata;
            end
            bus.cpu_ack <= !owner_ld;
            bus.ld_ack  <= owner_ld;
            state       <= ACK;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ACK: begin
          bus.cpu_ack <= 1'b0;
          bus.ld_ack  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chinpo_mem_arbiter.sv
// Bench for chinpo_mem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-count / transaction reference model.
module tb_chinpo_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic CLK      = 1'b0;
  logic Reset    = 1'b0;
  logic init_req = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_cpu_rd, exp_ld_rd;

  logic       p0_v = 1'b0, p1_v = 1'b0, q_v = 1'b0;
  logic [7:0] p0_a = 8'd0, p1_a = 8'd0, q_a = 8'd0;

  always #5 CLK = ~CLK;

  chinpo_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  chinpo_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  chinpo_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus));
  chinpo_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .CLK(CLK), .Reset(Reset), .bus(bus1));

  function automatic logic [15:0] init_val(input int a);
    return (a == 4) ? 16'hBEEF : (16'(a * 977) ^ 16'h5A5A);
  endfunction

  // Memory model: read data is valid only in the cycle the arbiter should capture it
  always @(posedge CLK) begin
    if (init_req) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    p0_v <= bus.mem_en && !bus.mem_we;
    p0_a <= bus.mem_addr[7:0];
    p1_v <= p0_v;
    p1_a <= p0_a;
    q_v  <= bus1.mem_en && !bus1.mem_we;
    q_a  <= bus1.mem_addr[7:0];
  end
  assign bus.mem_rdata  = p1_v ? mem[p1_a] : 16'hDEAD;
  assign bus1.mem_rdata = q_v  ? mem[q_a]  : 16'hDEAD;

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ld_req  = 0; bus.ld_we  = 0; bus.ld_addr  = 0; bus.ld_wdata  = 0;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
    bus1.ld_req  = 0; bus1.ld_we  = 0; bus1.ld_addr  = 0; bus1.ld_wdata  = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge CLK);
    init_req = 1'b0;
    checks++; if ({bus.mem_en, bus.mem_we, bus.cpu_ack, bus.ld_ack, bus.busy, bus.cpu_stall} !== 6'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=000000", {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.ld_ack, bus.busy, bus.cpu_stall}); end
    checks++; if (bus.mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0000", bus.mem_wdata); end
    checks++; if (bus.cpu_rdata !== 16'h0) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=0000", bus.cpu_rdata); end
    checks++; if (bus.ld_rdata !== 16'h0) begin failures++; $display("FAIL reset_ld_rdata got=%h exp=0000", bus.ld_rdata); end
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if ({bus.busy, bus1.busy, bus.mem_en} !== 3'b0) begin failures++; $display("FAIL reset_release_idle got=%b exp=000", {bus.busy, bus1.busy, bus.mem_en}); end
    exp_cpu_rd = 16'h0;
    exp_ld_rd  = 16'h0;
  endtask

  task automatic test_cpu_read();
    int ack_k = -1;
    int acks  = 0;
    bus.cpu_we = 0; bus.cpu_addr = 16'h0004; bus.cpu_wdata = 16'h0; bus.cpu_req = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        checks++; if ({bus.mem_en, bus.mem_we, bus.busy, bus.cpu_stall} !== 4'b1011) begin failures++; $display("FAIL rd_issue en/we/busy/stall got=%b exp=1011", {bus.mem_en, bus.mem_we, bus.busy, bus.cpu_stall}); end
        checks++; if (bus.mem_addr !== 16'h0004) begin failures++; $display("FAIL rd_issue_addr got=%h exp=0004", bus.mem_addr); end
      end
      if (k == 2) begin
        checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL rd_en_one_cycle got=%b exp=0", bus.mem_en); end
      end
      if (bus.cpu_ack === 1'b1) begin acks++; if (ack_k < 0) ack_k = k; bus.cpu_req = 0; end
    end
    checks++; if (ack_k != LAT + 2) begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=%0d", ack_k, LAT + 2); end
    checks++; if (acks != 1) begin failures++; $display("FAIL rd_ack_count got=%0d exp=1", acks); end
    checks++; if (bus.cpu_rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_cpu_rdata got=%h exp=beef", bus.cpu_rdata); end
    checks++; if (bus.ld_rdata !== exp_ld_rd) begin failures++; $display("FAIL rd_ld_rdata_held got=%h exp=%h", bus.ld_rdata, exp_ld_rd); end
    exp_cpu_rd = 16'hBEEF;
  endtask

  task automatic test_ld_write();
    int ack_k = -1;
    int acks  = 0;
    int cacks = 0;
    bus.ld_we = 1; bus.ld_addr = 16'h0020; bus.ld_wdata = 16'h1234; bus.ld_req = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        checks++; if ({bus.mem_en, bus.mem_we} !== 2'b11) begin failures++; $display("FAIL wr_issue en/we got=%b exp=11", {bus.mem_en, bus.mem_we}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== {16'h0020, 16'h1234}) begin failures++; $display("FAIL wr_issue addr/data got=%h/%h exp=0020/1234", bus.mem_addr, bus.mem_wdata); end
      end
      if (bus.cpu_ack === 1'b1) cacks++;
      if (bus.ld_ack === 1'b1) begin acks++; if (ack_k < 0) ack_k = k; bus.ld_req = 0; end
    end
    checks++; if (ack_k != LAT + 2 || acks != 1 || cacks != 0) begin failures++; $display("FAIL wr_ack got cycle=%0d ld_acks=%0d cpu_acks=%0d exp cycle=%0d ld_acks=1 cpu_acks=0", ack_k, acks, cacks, LAT + 2); end
    checks++; if ({bus.cpu_rdata, bus.ld_rdata} !== {exp_cpu_rd, exp_ld_rd}) begin failures++; $display("FAIL wr_rdata_held got=%h/%h exp=%h/%h", bus.cpu_rdata, bus.ld_rdata, exp_cpu_rd, exp_ld_rd); end
    ref_mem[8'h20] = 16'h1234;
  endtask

  task automatic test_starvation();
    int  gi  = 0;
    int  cyc = 0;
    bit  is_ld;
    bus.cpu_we = 0; bus.cpu_addr = 16'h0030;
    bus.ld_we  = 0; bus.ld_addr  = 16'h0040;
    bus.cpu_req = 1; bus.ld_req = 1;
    while (gi < 12 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (bus.mem_en === 1'b1) begin
        is_ld = (bus.mem_addr === 16'h0040);
        checks++; if (is_ld != ((gi % 5) == 4)) begin failures++; $display("FAIL starve_seq grant=%0d got_ld=%0d exp_ld=%0d", gi, is_ld, (gi % 5) == 4); end
        if (is_ld) begin
          checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL starve_stall grant=%0d got=%b exp=1", gi, bus.cpu_stall); end
        end
        gi++;
        if (gi == 12) begin bus.cpu_req = 0; bus.ld_req = 0; end
      end
    end
    checks++; if (gi != 12) begin failures++; $display("FAIL starve_timeout grants got=%0d exp=12", gi); end
    bus.cpu_req = 0; bus.ld_req = 0;
    repeat (8) @(negedge CLK);
    exp_cpu_rd = ref_mem[8'h30];
    exp_ld_rd  = ref_mem[8'h40];
    checks++; if ({bus.busy, bus.cpu_rdata, bus.ld_rdata} !== {1'b0, exp_cpu_rd, exp_ld_rd}) begin failures++; $display("FAIL starve_end busy/rd got=%b/%h/%h exp=0/%h/%h", bus.busy, bus.cpu_rdata, bus.ld_rdata, exp_cpu_rd, exp_ld_rd); end
  endtask

  task automatic test_withdrawn();
    int          ens   = 0;
    int          acks  = 0;
    int          ack_k = -1;
    logic [15:0] en_addr = 16'hFFFF;
    bus.cpu_we = 0; bus.cpu_addr = 16'h0050; bus.cpu_req = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (bus.mem_en === 1'b1) begin ens++; if (ens == 1) en_addr = bus.mem_addr; end
      if (bus.cpu_ack === 1'b1) begin acks++; if (ack_k < 0) ack_k = k; end
      if (k == 2) begin bus.cpu_req = 0; bus.cpu_addr = 16'h0077; end
    end
    checks++; if (ens != 1 || en_addr !== 16'h0050) begin failures++; $display("FAIL wd_issue got ens=%0d addr=%h exp ens=1 addr=0050", ens, en_addr); end
    checks++; if (acks != 1 || ack_k != LAT + 2) begin failures++; $display("FAIL wd_ack got acks=%0d cycle=%0d exp acks=1 cycle=%0d", acks, ack_k, LAT + 2); end
    exp_cpu_rd = ref_mem[8'h50];
    checks++; if (bus.cpu_rdata !== exp_cpu_rd) begin failures++; $display("FAIL wd_rdata got=%h exp=%h", bus.cpu_rdata, exp_cpu_rd); end
  endtask

  task automatic test_mem_lat1();
    int       ack_k = -1;
    logic [8:0] busy_bits = 9'b0;
    bus1.cpu_we = 0; bus1.cpu_addr = 16'h0004; bus1.cpu_req = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      busy_bits[k] = bus1.busy;
      if (k == 1) begin
        checks++; if ({bus1.mem_en, bus1.mem_addr} !== {1'b1, 16'h0004}) begin failures++; $display("FAIL lat1_issue got=%b/%h exp=1/0004", bus1.mem_en, bus1.mem_addr); end
      end
      if (bus1.cpu_ack === 1'b1) begin if (ack_k < 0) ack_k = k; bus1.cpu_req = 0; end
    end
    checks++; if (ack_k != 3) begin failures++; $display("FAIL lat1_ack_cycle got=%0d exp=3", ack_k); end
    checks++; if (busy_bits !== 9'b000001110) begin failures++; $display("FAIL lat1_busy got=%b exp=000001110", busy_bits); end
    checks++; if (bus1.cpu_rdata !== ref_mem[4]) begin failures++; $display("FAIL lat1_rdata got=%h exp=%h", bus1.cpu_rdata, ref_mem[4]); end
  endtask

  task automatic test_reset_mid_wait();
    int acks = 0;
    int busy_seen = 0;
    bus.cpu_we = 0; bus.cpu_addr = 16'h0010; bus.cpu_req = 1;
    repeat (2) @(negedge CLK);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_wait_busy got=%b exp=1", bus.busy); end
    Reset = 1'b0;
    bus.cpu_req = 0;
    #1;
    checks++; if ({bus.mem_en, bus.cpu_ack, bus.busy, bus.cpu_rdata} !== {3'b000, 16'h0}) begin failures++; $display("FAIL rst_async got=%b/%h exp=000/0000", {bus.mem_en, bus.cpu_ack, bus.busy}, bus.cpu_rdata); end
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (bus.cpu_ack === 1'b1) acks++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    checks++; if (acks != 0 || busy_seen != 0) begin failures++; $display("FAIL rst_abandon got acks=%0d busy_cycles=%0d exp 0/0", acks, busy_seen); end
    exp_cpu_rd = 16'h0;
    exp_ld_rd  = 16'h0;
  endtask

  task automatic test_random(input int ncyc);
    bit          c_out = 0, l_out = 0, inflight = 0, own_ld = 0, e_we = 0;
    bit          x_en, x_busy, x_cack, x_lack;
    int          g = 0, starve = 0;
    logic [15:0] e_addr = 0, e_wd = 0, e_rd = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge CLK);
      x_en   = inflight && (n == g);
      x_busy = inflight && (n >= g) && (n <= g + 1 + LAT);
      x_cack = inflight && (n == g + 1 + LAT) && !own_ld;
      x_lack = inflight && (n == g + 1 + LAT) && own_ld;
      if (x_cack && !e_we) exp_cpu_rd = e_rd;
      if (x_lack && !e_we) exp_ld_rd  = e_rd;
      checks++; if ({bus.mem_en, bus.busy, bus.cpu_ack, bus.ld_ack} !== {x_en, x_busy, x_cack, x_lack}) begin failures++; $display("FAIL rnd_ctrl cyc=%0d en/busy/cack/lack got=%b exp=%b", n, {bus.mem_en, bus.busy, bus.cpu_ack, bus.ld_ack}, {x_en, x_busy, x_cack, x_lack}); end
      checks++; if ({bus.cpu_rdata, bus.ld_rdata} !== {exp_cpu_rd, exp_ld_rd}) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", n, bus.cpu_rdata, bus.ld_rdata, exp_cpu_rd, exp_ld_rd); end
      checks++; if (bus.cpu_stall !== (bus.cpu_req && !x_cack)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", n, bus.cpu_stall, bus.cpu_req && !x_cack); end
      if (x_en) begin
        checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {e_we, e_addr, e_wd}) begin failures++; $display("FAIL rnd_issue cyc=%0d we/addr/data got=%b/%h/%h exp=%b/%h/%h", n, bus.mem_we, bus.mem_addr, bus.mem_wdata, e_we, e_addr, e_wd); end
      end
      // Requesters: hold until ack, drop on ack, may scramble or withdraw once granted
      if (x_cack) begin bus.cpu_req = 0; c_out = 0; end
      else if (!c_out && $urandom_range(0, 1) == 1) begin
        c_out = 1; bus.cpu_req = 1; bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom);
      end
      if (x_lack) begin bus.ld_req = 0; l_out = 0; end
      else if (!l_out && $urandom_range(0, 2) == 0) begin
        l_out = 1; bus.ld_req = 1; bus.ld_we = 1'($urandom_range(0, 1));
        bus.ld_addr = 16'($urandom); bus.ld_wdata = 16'($urandom);
      end
      if (x_en) begin
        if (own_ld) begin
          bus.ld_addr = 16'($urandom); bus.ld_wdata = 16'($urandom); bus.ld_we = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) bus.ld_req = 0;
        end else begin
          bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom); bus.cpu_we = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) bus.cpu_req = 0;
        end
      end
      if (!x_busy) begin
        if (!bus.ld_req) starve = 0;
        if (bus.cpu_req || bus.ld_req) begin
          own_ld = bus.ld_req && (!bus.cpu_req || starve == SMAX);
          if (own_ld) starve = 0;
          else if (bus.ld_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
          e_we   = own_ld ? bus.ld_we    : bus.cpu_we;
          e_addr = own_ld ? bus.ld_addr  : bus.cpu_addr;
          e_wd   = own_ld ? bus.ld_wdata : bus.cpu_wdata;
          if (e_we) ref_mem[e_addr[7:0]] = e_wd;
          else      e_rd = ref_mem[e_addr[7:0]];
          g = n + 1;
          inflight = 1;
        end
      end
    end
    bus.cpu_req = 0; bus.ld_req = 0;
    repeat (8) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_cpu_read();
    test_ld_write();
    test_starvation();
    test_withdrawn();
    test_mem_lat1();
    test_reset_mid_wait();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
